// File: rtl/memory_pkg.sv
// Shared dimensions and fixed reset contents for the convolution image/filter store.
package memory_pkg;

   localparam int IMG_DIM = 4;
   localparam int K_DIM   = 3;
   localparam int IMG_N   = IMG_DIM * IMG_DIM;
   localparam int K_N     = K_DIM * K_DIM;
   localparam int DATA_W  = 8;

   // Image pixels, row-major (index = row*IMG_DIM + col).
   localparam logic [DATA_W-1:0] IMG_INIT [0:IMG_N-1] = '{
      8'h01, 8'h02, 8'h03, 8'h04,
      8'h05, 8'h06, 8'h07, 8'h08,
      8'h09, 8'h0a, 8'h0b, 8'h0c,
      8'h0d, 8'h0e, 8'h0f, 8'h10
   };

   // Filter taps, row-major (index = row*K_DIM + col): a 1-2-1 smoothing kernel.
   localparam logic [DATA_W-1:0] FILTER_INIT [0:K_N-1] = '{
      8'h01, 8'h02, 8'h01,
      8'h02, 8'h04, 8'h02,
      8'h01, 8'h02, 8'h01
   };

   // Flatten the image table so element i lands in bits [i*DATA_W +: DATA_W].
   function automatic logic [IMG_N*DATA_W-1:0] pack_img();
      logic [IMG_N*DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < IMG_N; i++) begin
         v[i*DATA_W +: DATA_W] = IMG_INIT[i];
      end
      return v;
   endfunction

   // Flatten the filter table with the same element ordering as pack_img.
   function automatic logic [K_N*DATA_W-1:0] pack_filter();
      logic [K_N*DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < K_N; i++) begin
         v[i*DATA_W +: DATA_W] = FILTER_INIT[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/memory_reg_bank.sv
// Bank of N registers of W bits that load a constant vector on synchronous reset
// and otherwise hold their contents forever.
module memory_reg_bank #(
   parameter int              N    = 16,
   parameter int              W    = 8,
   parameter logic [N*W-1:0]  INIT = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic [N-1:0][W-1:0] q
);

   // Load the constants on a reset edge; with no write path the value simply holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= INIT;
      end
   end

endmodule

// File: rtl/memory.sv
// Register store for a 4x4 image and a 3x3 filter. Contents are fixed constants
// loaded by reset; every element is a register driving its own output port.
// DATA_W must match memory_pkg::DATA_W (8); the constant tables are 8-bit.
module memory #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] input_data0,
   output logic [DATA_W-1:0] input_data1,
   output logic [DATA_W-1:0] input_data2,
   output logic [DATA_W-1:0] input_data3,
   output logic [DATA_W-1:0] input_data4,
   output logic [DATA_W-1:0] input_data5,
   output logic [DATA_W-1:0] input_data6,
   output logic [DATA_W-1:0] input_data7,
   output logic [DATA_W-1:0] input_data8,
   output logic [DATA_W-1:0] input_data9,
   output logic [DATA_W-1:0] input_data10,
   output logic [DATA_W-1:0] input_data11,
   output logic [DATA_W-1:0] input_data12,
   output logic [DATA_W-1:0] input_data13,
   output logic [DATA_W-1:0] input_data14,
   output logic [DATA_W-1:0] input_data15,
   output logic [DATA_W-1:0] filter_data0,
   output logic [DATA_W-1:0] filter_data1,
   output logic [DATA_W-1:0] filter_data2,
   output logic [DATA_W-1:0] filter_data3,
   output logic [DATA_W-1:0] filter_data4,
   output logic [DATA_W-1:0] filter_data5,
   output logic [DATA_W-1:0] filter_data6,
   output logic [DATA_W-1:0] filter_data7,
   output logic [DATA_W-1:0] filter_data8
);

   import memory_pkg::IMG_N;
   import memory_pkg::K_N;
   import memory_pkg::pack_img;
   import memory_pkg::pack_filter;

   logic [IMG_N-1:0][DATA_W-1:0] img_q;
   logic [K_N-1:0][DATA_W-1:0]   flt_q;

   memory_reg_bank #(
      .N    (IMG_N),
      .W    (DATA_W),
      .INIT (pack_img())
   ) u_img_bank (
      .clk (clk),
      .rst (rst),
      .q   (img_q)
   );

   memory_reg_bank #(
      .N    (K_N),
      .W    (DATA_W),
      .INIT (pack_filter())
   ) u_filter_bank (
      .clk (clk),
      .rst (rst),
      .q   (flt_q)
   );

   // Outputs are wired straight from the registers: no logic between storage and ports.
   assign input_data0  = img_q[0];
   assign input_data1  = img_q[1];
   assign input_data2  = img_q[2];
   assign input_data3  = img_q[3];
   assign input_data4  = img_q[4];
   assign input_data5  = img_q[5];
   assign input_data6  = img_q[6];
   assign input_data7  = img_q[7];
   assign input_data8  = img_q[8];
   assign input_data9  = img_q[9];
   assign input_data10 = img_q[10];
   assign input_data11 = img_q[11];
   assign input_data12 = img_q[12];
   assign input_data13 = img_q[13];
   assign input_data14 = img_q[14];
   assign input_data15 = img_q[15];

   assign filter_data0 = flt_q[0];
   assign filter_data1 = flt_q[1];
   assign filter_data2 = flt_q[2];
   assign filter_data3 = flt_q[3];
   assign filter_data4 = flt_q[4];
   assign filter_data5 = flt_q[5];
   assign filter_data6 = flt_q[6];
   assign filter_data7 = flt_q[7];
   assign filter_data8 = flt_q[8];

endmodule

// File: tb/tb_memory.sv
// Bench for the constant image/filter store: a driver issues reset/hold cycles and
// pushes the expected 25-element snapshot per edge; a monitor pops and compares.
module tb_memory;

   localparam int W   = 8;
   localparam int NEL = 25;
   localparam int VW  = NEL * W;

   logic clk;
   logic rst;

   logic [W-1:0] input_data0,  input_data1,  input_data2,  input_data3;
   logic [W-1:0] input_data4,  input_data5,  input_data6,  input_data7;
   logic [W-1:0] input_data8,  input_data9,  input_data10, input_data11;
   logic [W-1:0] input_data12, input_data13, input_data14, input_data15;
   logic [W-1:0] filter_data0, filter_data1, filter_data2;
   logic [W-1:0] filter_data3, filter_data4, filter_data5;
   logic [W-1:0] filter_data6, filter_data7, filter_data8;

   // Element k at [k*W +: W]: 0..15 image pixels, 16..24 filter taps.
   logic [VW-1:0] dut_vec;
   assign dut_vec = {filter_data8, filter_data7, filter_data6, filter_data5, filter_data4,
                     filter_data3, filter_data2, filter_data1, filter_data0,
                     input_data15, input_data14, input_data13, input_data12,
                     input_data11, input_data10, input_data9,  input_data8,
                     input_data7,  input_data6,  input_data5,  input_data4,
                     input_data3,  input_data2,  input_data1,  input_data0};

   logic [VW-1:0] exp_q[$];
   int checks;
   int failures;
   bit loaded;
   bit watch_toggles;
   int toggles;

   memory #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .input_data0  (input_data0),
      .input_data1  (input_data1),
      .input_data2  (input_data2),
      .input_data3  (input_data3),
      .input_data4  (input_data4),
      .input_data5  (input_data5),
      .input_data6  (input_data6),
      .input_data7  (input_data7),
      .input_data8  (input_data8),
      .input_data9  (input_data9),
      .input_data10 (input_data10),
      .input_data11 (input_data11),
      .input_data12 (input_data12),
      .input_data13 (input_data13),
      .input_data14 (input_data14),
      .input_data15 (input_data15),
      .filter_data0 (filter_data0),
      .filter_data1 (filter_data1),
      .filter_data2 (filter_data2),
      .filter_data3 (filter_data3),
      .filter_data4 (filter_data4),
      .filter_data5 (filter_data5),
      .filter_data6 (filter_data6),
      .filter_data7 (filter_data7),
      .filter_data8 (filter_data8)
   );

   // Clock: 10 ns period, first rising edge at 5 ns.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference contents: pixels count up from 1; the filter is the outer
   // product of the 1-2-1 vector with itself.
   function automatic logic [VW-1:0] model_contents();
      logic [VW-1:0] v;
      int w[3];
      w = '{1, 2, 1};
      v = '0;
      for (int i = 0; i < 16; i++) v[i*W +: W] = W'(i + 1);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            v[(16 + r*3 + c)*W +: W] = W'(w[r] * w[c]);
      return v;
   endfunction

   // One clock cycle with rst at the given level; once any reset edge has
   // occurred the contents are defined and a snapshot is expected.
   task automatic step(input bit r);
      @(negedge clk);
      rst = r;
      @(posedge clk);
      #1;
      if (r) loaded = 1'b1;
      if (loaded) exp_q.push_back(model_contents());
   endtask

   task automatic hold_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   // Short rst pulse strictly between edges; must not affect the registers.
   task automatic async_glitch();
      @(posedge clk);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Monitor: compare every element of the current DUT snapshot with the expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [VW-1:0] exp_v;
         exp_v = exp_q.pop_front();
         for (int k = 0; k < NEL; k++) begin
            checks++;
            if (dut_vec[k*W +: W] !== exp_v[k*W +: W]) begin
               failures++;
               if (k < 16)
                  $display("FAIL input_data%0d got=%h exp=%h t=%0t", k, dut_vec[k*W +: W], exp_v[k*W +: W], $time);
               else
                  $display("FAIL filter_data%0d got=%h exp=%h t=%0t", k-16, dut_vec[k*W +: W], exp_v[k*W +: W], $time);
            end
         end
      end
   end

   // Any output change after the store has been loaded is an unwanted toggle.
   always @(dut_vec) begin
      if (watch_toggles) toggles++;
   end

   initial begin
      int n;
      checks = 0;
      failures = 0;
      loaded = 1'b0;
      watch_toggles = 1'b0;
      toggles = 0;
      rst = 1'b1;

      // First reset edge, then the store must be defined.
      @(posedge clk);
      #1;
      loaded = 1'b1;
      exp_q.push_back(model_contents());
      checks++;
      if ($isunknown(dut_vec)) begin
         failures++;
         $display("FAIL defined_after_reset got=%h exp=no_x", dut_vec);
      end
      watch_toggles = 1'b1;

      hold_cycles(10);
      hold_cycles(5);
      step(1'b1);
      hold_cycles(5);

      async_glitch();
      hold_cycles(3);
      checks++;
      if (input_data5 !== 8'h06 || filter_data4 !== 8'h04) begin
         failures++;
         $display("FAIL glitch_probe got=%h/%h exp=06/04", input_data5, filter_data4);
      end

      step(1'b1);
      step(1'b1);
      step(1'b1);
      hold_cycles(4);

      // Randomized mix of hold runs, reset pulses and between-edge glitches.
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 3);
         if (n == 0) step(1'b1);
         else if (n == 1) async_glitch();
         else hold_cycles($urandom_range(1, 4));
      end
      step(1'b0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end

      checks++;
      if (toggles != 0) begin
         failures++;
         $display("FAIL output_toggles got=%0d exp=0", toggles);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
